// File: rtl/data_arith_extend_sched_pkg.sv
// Shared types for the extension-lane scheduler and its round-robin picker.
package data_arith_extend_sched_pkg;

  typedef enum logic {
    EXT_ZERO = 1'b0,
    EXT_SIGN = 1'b1
  } ext_mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } sched_state_e;

  // Index width for n requesters; at least one bit so a single requester still has an id.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_control_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod N.
module data_control_rr_pick
  import data_arith_extend_sched_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]            req,
  input  logic [id_width(N)-1:0]  ptr,
  output logic [N-1:0]            grant,
  output logic [id_width(N)-1:0]  idx,
  output logic                    any
);

  localparam int unsigned ID_W = id_width(N);

  int unsigned pos;
  logic [ID_W-1:0] pos_idx;

  always_comb begin
    grant   = '0;
    idx     = '0;
    any     = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos     = (32'(ptr) + k) % N;
      pos_idx = ID_W'(pos);
      if (!any && req[pos_idx]) begin
        grant[pos_idx] = 1'b1;
        idx            = pos_idx;
        any            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_arith_extend_sched.sv
// Round-robin shared sign/zero-extension lane with a one-entry registered output stage.
module data_arith_extend_sched
  import data_arith_extend_sched_pkg::*;
#(
  parameter int unsigned REQ_N = 4,
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REQ_N-1:0]              req_valid,
  output logic [REQ_N-1:0]              req_ready,
  input  logic [REQ_N*IN_W-1:0]         req_data,
  input  logic [REQ_N-1:0]              req_signed,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_data,
  output logic [id_width(REQ_N)-1:0]    out_id
);

  localparam int unsigned ID_W = id_width(REQ_N);

  if (OUT_W < IN_W) begin : g_bad_width
    $error("data_arith_extend_sched: OUT_W must be >= IN_W");
  end

  sched_state_e     state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]  out_id_q, out_id_d;

  logic [REQ_N-1:0] pick_grant;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic             can_accept;

  logic [IN_W-1:0]  req_arr [REQ_N];
  logic [IN_W-1:0]  sel_data;
  logic             sel_signed;
  logic [OUT_W-1:0] ext_data;

  for (genvar i = 0; i < REQ_N; i++) begin : g_unpack
    assign req_arr[i] = req_data[i*IN_W +: IN_W];
  end

  data_control_rr_pick #(.N(REQ_N)) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Datapath: mux the granted operand, then extend it; off the req_ready path.
  assign sel_data   = req_arr[pick_idx];
  assign sel_signed = (ext_mode_e'(req_signed[pick_idx]) == EXT_SIGN);

  if (OUT_W == IN_W) begin : g_pass
    assign ext_data = sel_data;
  end else begin : g_ext
    localparam int unsigned EXT_W = OUT_W - IN_W;
    assign ext_data = {{EXT_W{sel_signed & sel_data[IN_W-1]}}, sel_data};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      ptr_q      <= '0;
      out_data_q <= '0;
      out_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
    end
  end

  // Next state: refill whenever the slot is empty or draining this cycle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    req_ready  = '0;
    can_accept = (state_q == ST_EMPTY) || out_ready;

    if (!rst && can_accept && pick_any) begin
      req_ready  = pick_grant;
      state_d    = ST_FULL;
      out_data_d = ext_data;
      out_id_d   = pick_idx;
      ptr_d      = ID_W'((32'(pick_idx) + 1) % REQ_N);
    end else if (state_q == ST_FULL && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_data_arith_extend_sched.sv
// Directed self-checking bench for data_arith_extend_sched with hand-computed expectations.
module tb_data_arith_extend_sched;

  localparam int unsigned REQ_N = 4;
  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [REQ_N-1:0]  req_valid;
  logic [REQ_N-1:0]  req_ready;
  logic [REQ_N*IN_W-1:0] req_data;
  logic [REQ_N-1:0]  req_signed;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [1:0]        out_id;

  int n_checks = 0;
  int n_pass   = 0;

  data_arith_extend_sched #(.REQ_N(REQ_N), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_signed (req_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [1:0] id, input logic [31:0] d);
    check({tag, " out_valid"}, 64'(out_valid), 64'(v));
    check({tag, " out_id"},    64'(out_id),    64'(id));
    check({tag, " out_data"},  64'(out_data),  64'(d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] exp_id;
    rst        = 1'b1;
    req_valid  = 4'b1111;
    out_ready  = 1'b0;
    req_signed = 4'b0000;
    for (int i = 0; i < REQ_N; i++) req_data[i*IN_W +: IN_W] = 16'h1000 + 16'(i);

    // Reset with everyone requesting.
    tick();
    tick();
    check("rst req_ready", 64'(req_ready), 64'(4'b0000));
    rst = 1'b0;
    #1;
    expect_out("post-rst", 1'b0, 2'd0, 32'h0);
    check("first grant", 64'(req_ready), 64'(4'b0001));
    tick();
    expect_out("first accept", 1'b1, 2'd0, 32'h0000_1000);

    // Fairness: one accept per cycle, rotating.
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_id = 2'((k + 1) % 4);
      expect_out($sformatf("rr%0d", k), 1'b1, exp_id, 32'h0000_1000 + 32'(exp_id));
    end

    // Backpressure: output holds, nothing accepted.
    out_ready = 1'b0;
    #1;
    check("bp req_ready", 64'(req_ready), 64'(4'b0000));
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out($sformatf("bp%0d", k), 1'b1, 2'd0, 32'h0000_1000);
      check($sformatf("bp%0d req_ready", k), 64'(req_ready), 64'(4'b0000));
    end
    out_ready = 1'b1;
    #1;
    check("bp release grant", 64'(req_ready), 64'(4'b0010));
    tick();
    expect_out("drain+refill", 1'b1, 2'd1, 32'h0000_1001);

    // Sign vs zero extension on requester 2.
    req_valid = 4'b0100;
    req_data[2*IN_W +: IN_W] = 16'h8001;
    req_signed = 4'b0100;
    tick();
    expect_out("signed", 1'b1, 2'd2, 32'hFFFF_8001);
    req_signed = 4'b0000;
    tick();
    expect_out("unsigned", 1'b1, 2'd2, 32'h0000_8001);

    // Sparse: steer ptr to 1, then lone requester 3, then lone requester 1.
    req_valid = 4'b0001;
    tick();
    expect_out("sparse r0", 1'b1, 2'd0, 32'h0000_1000);
    req_valid = 4'b1000;
    #1;
    check("sparse grant3", 64'(req_ready), 64'(4'b1000));
    tick();
    expect_out("sparse r3", 1'b1, 2'd3, 32'h0000_1003);
    req_valid = 4'b0010;
    #1;
    check("sparse grant1", 64'(req_ready), 64'(4'b0010));
    tick();
    expect_out("sparse r1", 1'b1, 2'd1, 32'h0000_1001);

    // Drain only: valid drops, stale data and id hold.
    req_valid = 4'b0000;
    tick();
    expect_out("drain", 1'b0, 2'd1, 32'h0000_1001);

    // Pointer held at 2 while idle: both 1 and 2 valid -> 2 wins.
    req_valid = 4'b0110;
    #1;
    check("ptr hold grant", 64'(req_ready), 64'(4'b0100));
    tick();
    expect_out("ptr hold accept", 1'b1, 2'd2, 32'h0000_8001);

    // Reset while holding a result under backpressure.
    req_valid = 4'b0000;
    out_ready = 1'b0;
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    check("mid rst req_ready", 64'(req_ready), 64'(4'b0000));
    tick();
    expect_out("mid rst", 1'b0, 2'd0, 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("restart grant", 64'(req_ready), 64'(4'b0001));
    tick();
    expect_out("restart", 1'b1, 2'd0, 32'h0000_1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
